// File: rtl/sm_collector_pkg.sv
// Shared parameters and FSM state encoding for the sorted-element collector.
package sm_collector_pkg;

  localparam int SM_DATA_WIDTH       = 32;
  localparam int SM_ELEMENT_NUM      = 16;
  localparam int SM_LOG2_ELEMENT_NUM = 4;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_DRAIN   = 1'b1;

endpackage

// File: rtl/sm_order_checker.sv
// Flags any drained beat (other than index 0) smaller than the beat transferred before it.
module sm_order_checker
  import sm_collector_pkg::*;
#(
  parameter int DATA_WIDTH       = SM_DATA_WIDTH,
  parameter int LOG2_ELEMENT_NUM = SM_LOG2_ELEMENT_NUM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        xfer,
  input  logic [LOG2_ELEMENT_NUM-1:0] idx,
  input  logic [DATA_WIDTH-1:0]       data,
  output logic                        err_order
);

  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic                  err_q, err_d;

  always_comb begin
    prev_d = prev_q;
    err_d  = err_q;
    if (xfer) begin
      prev_d = data;
      if ((idx != {LOG2_ELEMENT_NUM{1'b0}}) && (data < prev_q)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      prev_d = prev_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= {DATA_WIDTH{1'b0}};
      err_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      err_q  <= err_d;
    end
  end

  assign err_order = err_q;

endmodule

// File: rtl/sm_collector.sv
// Collects sorter writes into a frame buffer, then drains it in address order
// over a valid/ready stream while tracking sticky integrity errors.
module sm_collector
  import sm_collector_pkg::*;
#(
  parameter int DATA_WIDTH       = SM_DATA_WIDTH,
  parameter int ELEMENT_NUM      = SM_ELEMENT_NUM,
  parameter int LOG2_ELEMENT_NUM = SM_LOG2_ELEMENT_NUM
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        SM_valid,
  input  logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
  input  logic [DATA_WIDTH-1:0]       SM_data,
  input  logic                        done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [LOG2_ELEMENT_NUM-1:0] out_idx,
  output logic                        out_last,
  output logic                        busy,
  output logic                        err_dup,
  output logic                        err_missing,
  output logic                        err_order,
  output logic                        err_overrun
);

  localparam logic [LOG2_ELEMENT_NUM-1:0] LAST_IDX = LOG2_ELEMENT_NUM'(ELEMENT_NUM - 1);
  localparam logic [LOG2_ELEMENT_NUM-1:0] ONE_IDX  = LOG2_ELEMENT_NUM'(1);

  logic [0:0]                  state_q, state_d;
  logic [LOG2_ELEMENT_NUM-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]       mem_q [ELEMENT_NUM];
  logic [DATA_WIDTH-1:0]       mem_d [ELEMENT_NUM];
  logic [ELEMENT_NUM-1:0]      wr_map_q, wr_map_d;
  logic                        done_q, done_d;
  logic                        err_dup_q, err_dup_d;
  logic                        err_missing_q, err_missing_d;
  logic                        err_overrun_q, err_overrun_d;
  logic                        done_rise;
  logic                        draining;
  logic                        xfer;

  assign done_rise = done & ~done_q;
  assign draining  = (state_q == ST_DRAIN);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_d         = mem_q;
    wr_map_d      = wr_map_q;
    done_d        = done;
    err_dup_d     = err_dup_q;
    err_missing_d = err_missing_q;
    err_overrun_d = err_overrun_q;
    xfer          = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (SM_valid) begin
          mem_d[SM_addr]    = SM_data;
          err_dup_d         = err_dup_q | wr_map_q[SM_addr];
          wr_map_d[SM_addr] = 1'b1;
        end else begin
          wr_map_d = wr_map_q;
        end
        // wr_map_d already includes a write accepted alongside the done rise
        if (done_rise) begin
          state_d       = ST_DRAIN;
          err_missing_d = err_missing_q | ~(&wr_map_d);
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DRAIN: begin
        err_overrun_d = err_overrun_q | SM_valid;
        xfer          = out_ready;
        if (out_ready) begin
          if (cnt_q == LAST_IDX) begin
            state_d  = ST_COLLECT;
            cnt_d    = {LOG2_ELEMENT_NUM{1'b0}};
            mem_d    = '{default: {DATA_WIDTH{1'b0}}};
            wr_map_d = {ELEMENT_NUM{1'b0}};
          end else begin
            cnt_d = cnt_q + ONE_IDX;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_COLLECT;
        cnt_d   = {LOG2_ELEMENT_NUM{1'b0}};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_COLLECT;
      cnt_q         <= {LOG2_ELEMENT_NUM{1'b0}};
      mem_q         <= '{default: {DATA_WIDTH{1'b0}}};
      wr_map_q      <= {ELEMENT_NUM{1'b0}};
      done_q        <= 1'b0;
      err_dup_q     <= 1'b0;
      err_missing_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_q         <= mem_d;
      wr_map_q      <= wr_map_d;
      done_q        <= done_d;
      err_dup_q     <= err_dup_d;
      err_missing_q <= err_missing_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign out_valid   = draining;
  assign busy        = draining;
  assign out_idx     = draining ? cnt_q : {LOG2_ELEMENT_NUM{1'b0}};
  assign out_data    = mem_q[out_idx];
  assign out_last    = draining & (cnt_q == LAST_IDX);
  assign err_dup     = err_dup_q;
  assign err_missing = err_missing_q;
  assign err_overrun = err_overrun_q;

  sm_order_checker #(
    .DATA_WIDTH       (DATA_WIDTH),
    .LOG2_ELEMENT_NUM (LOG2_ELEMENT_NUM)
  ) u_order_checker (
    .clk       (clk),
    .rst       (rst),
    .xfer      (xfer),
    .idx       (cnt_q),
    .data      (out_data),
    .err_order (err_order)
  );

endmodule
